// File: rtl/weight_sram_stream.sv
// Weight store with per-parameter masked writes and a burst read engine that
// streams consecutive words (wrapping at DEPTH) to the PE array over valid/ready.
module weight_sram_stream #(
  parameter int WEIGHT_PER_ADDR = 9,
  parameter int BW_PER_PARAM    = 8,
  parameter int DEPTH           = 640,
  parameter int ADDR_W          = 10
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     csb,
  input  logic                                     wsb,
  input  logic [WEIGHT_PER_ADDR-1:0]               wmask,
  input  logic [ADDR_W-1:0]                        waddr,
  input  logic [WEIGHT_PER_ADDR*BW_PER_PARAM-1:0]  wdata,
  input  logic                                     burst_start,
  input  logic [ADDR_W-1:0]                        burst_base,
  input  logic [ADDR_W:0]                          burst_len,
  input  logic                                     burst_abort,
  output logic                                     burst_busy,
  output logic                                     rvalid,
  input  logic                                     rready,
  output logic [WEIGHT_PER_ADDR*BW_PER_PARAM-1:0]  rdata,
  output logic                                     rlast
);

  localparam int DW = WEIGHT_PER_ADDR * BW_PER_PARAM;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  logic [DW-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [ADDR_W:0]   out_left_q, out_left_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic [DW-1:0]     e0_q, e0_d, e1_q, e1_d;
  logic              rvalid_q, rvalid_d, rlast_q, rlast_d;

  logic [DW-1:0]     rd_word_s;
  logic [ADDR_W-1:0] base_mod_s;
  logic [2:0]        occ_sum_s;
  logic              pop_s, issue_s, start_ok_s, done_s;

  // Masked word write; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (!csb && !wsb && ({1'b0, waddr} < DEPTH_L)) begin
      for (int k = 0; k < WEIGHT_PER_ADDR; k++) begin
        if (wmask[k]) begin
          mem[waddr][k*BW_PER_PARAM +: BW_PER_PARAM] <= wdata[k*BW_PER_PARAM +: BW_PER_PARAM];
        end
      end
    end
  end

  assign rd_word_s  = mem[rd_ptr_q];
  assign base_mod_s = ADDR_W'(32'(burst_base) % 32'(DEPTH));
  assign occ_sum_s  = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign pop_s      = rvalid_q && rready;
  assign start_ok_s = burst_start && (burst_len != LEN_ZERO) && (burst_len <= DEPTH_L);
  assign done_s     = pop_s && (out_left_q == LEN_ONE);
  // Issue only while the FIFO plus the read issued last cycle leave room after this cycle's pop.
  assign issue_s    = (state_q == RUN) && !burst_abort && (remaining_q != LEN_ZERO) &&
                      (occ_sum_s < (3'd2 + {2'b00, pop_s}));

  // Next-state for burst control and the 2-entry output FIFO (entry 0 is the head).
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    out_left_d  = out_left_q;
    cnt_d       = cnt_q;
    inflight_d  = issue_s;
    e0_d        = e0_q;
    e1_d        = e1_q;
    case (state_q)
      IDLE: begin
        if (start_ok_s) begin
          state_d     = RUN;
          rd_ptr_d    = base_mod_s;
          remaining_d = burst_len;
          out_left_d  = burst_len;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (burst_abort) begin
          state_d     = IDLE;
          remaining_d = LEN_ZERO;
          out_left_d  = LEN_ZERO;
          cnt_d       = 2'd0;
          inflight_d  = 1'b0;
        end else begin
          if (issue_s) begin
            rd_ptr_d    = (rd_ptr_q == LAST_ADDR) ? ADDR_ZERO : rd_ptr_q + ADDR_ONE;
            remaining_d = remaining_q - LEN_ONE;
          end else begin
            rd_ptr_d    = rd_ptr_q;
          end
          if (pop_s) begin
            out_left_d = out_left_q - LEN_ONE;
          end else begin
            out_left_d = out_left_q;
          end
          if (done_s) begin
            state_d = IDLE;
          end else begin
            state_d = RUN;
          end
          case ({issue_s, pop_s})
            2'b10: begin
              if (cnt_q == 2'd0) begin
                e0_d = rd_word_s;
              end else begin
                e1_d = rd_word_s;
              end
              cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
              e0_d  = e1_q;
              cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
              if (cnt_q == 2'd1) begin
                e0_d = rd_word_s;
              end else begin
                e0_d = e1_q;
                e1_d = rd_word_s;
              end
            end
            default: cnt_d = cnt_q;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    rvalid_d = (cnt_d != 2'd0);
    rlast_d  = rvalid_d && (out_left_d == LEN_ONE);
  end

  // Burst state, FIFO and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_ptr_q    <= ADDR_ZERO;
      remaining_q <= LEN_ZERO;
      out_left_q  <= LEN_ZERO;
      cnt_q       <= 2'd0;
      inflight_q  <= 1'b0;
      e0_q        <= {DW{1'b0}};
      e1_q        <= {DW{1'b0}};
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      out_left_q  <= out_left_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      e0_q        <= e0_d;
      e1_q        <= e1_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
    end
  end

  assign burst_busy = (state_q == RUN);
  assign rvalid     = rvalid_q;
  assign rlast      = rlast_q;
  assign rdata      = e0_q;

endmodule

// File: doc/weight_sram_stream.md
# weight_sram_stream

Parametrised successor to the fixed 640x72b weight SRAM: a DEPTH x (WEIGHT_PER_ADDR*BW_PER_PARAM) weight store with per-parameter masked writes and a burst read engine that streams consecutive words over a valid/ready interface. It sits between the weight loader (write side) and the conv PE array (read side). The PE array requests a layer's weights with one base/length command instead of driving addresses every cycle.

## Interface
- WEIGHT_PER_ADDR, 9, parameters per word
- BW_PER_PARAM, 8, bits per parameter
- DEPTH, 640, words stored
- ADDR_W, 10, address width; ADDR_W >= clog2(DEPTH)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- csb  in  1  chip select, active low; gates writes only
- wsb  in  1  write enable, active low
- wmask  in  WEIGHT_PER_ADDR  per-parameter write enable, active high
- waddr  in  ADDR_W  write address
- wdata  in  WEIGHT_PER_ADDR*BW_PER_PARAM  write data
- burst_start  in  1  single-cycle burst command
- burst_base  in  ADDR_W  first read address, sampled with burst_start
- burst_len  in  ADDR_W+1  word count, sampled with burst_start
- burst_abort  in  1  cancel the current burst
- burst_busy  out  1  burst in progress
- rvalid  out  1  rdata valid
- rready  in  1  consumer accepts rdata
- rdata  out  WEIGHT_PER_ADDR*BW_PER_PARAM  read word
- rlast  out  1  marks the final word of the burst, qualified by rvalid

## Operation
- Write: when ~csb & ~wsb, mem[waddr] slice k is loaded from wdata slice k for every k with wmask[k]=1. Other slices are unchanged. waddr >= DEPTH is ignored. Writes are accepted in any state.
- Memory contents are not reset.
- FSM states are IDLE and RUN.
- IDLE to RUN: burst_start=1 and 1 <= burst_len <= DEPTH.
  - On this transition, rd_ptr is loaded with burst_base mod DEPTH, remaining is loaded with burst_len, and the output count is loaded with burst_len.
  - burst_len = 0 or burst_len > DEPTH: the command is ignored and the block stays in IDLE.
- burst_start while in RUN is ignored.
- Issue rule (RUN): one SRAM read is issued per cycle when remaining > 0 and (occupancy + inflight - pop) < 2.
  - occupancy is the output FIFO count (0..2).
  - inflight is 1 if a read was issued in the previous cycle.
  - pop = rvalid & rready.
- After each issue, rd_ptr increments and wraps from DEPTH-1 to 0, and remaining decrements.
- Read data enters the 2-entry output FIFO one cycle after issue. rdata/rvalid always present the FIFO head.
- rlast=1 when the head word is the burst's final word.
- RUN to IDLE: in the cycle the rlast word pops, or on burst_abort.
- burst_abort: the FIFO is flushed, the in-flight read is discarded, and the next cycle shows rvalid=0 and burst_busy=0. abort takes priority over a same-cycle pop. abort in IDLE has no effect.
- Read and write to the same address in the same cycle: the read returns the old data; the new data is visible to reads issued from the next cycle on.
- burst_busy = (state == RUN).

## Timing
- Reset (async assert, sync release) clears:
  - outputs: burst_busy=0, rvalid=0, rlast=0, rdata=0
  - internal state: FIFO, inflight, pointers; state goes to IDLE
- Reset mid-burst aborts it immediately; no word is delivered after reset.
- Latency: burst_start at cycle T gives burst_busy=1 at T+1, the first issue at T+1, and the first rvalid at T+2.
- With rready held at 1, the block sustains one word per cycle. An N-word burst has rvalid high in cycles T+2..T+N+1 with rlast at T+N+1, and burst_busy=0 at T+N+2.
- Handshake: while rvalid=1 & rready=0, rdata and rlast are held stable. The block never drops or duplicates a word under any rready pattern.
- A new burst_start is accepted in the first cycle burst_busy=0, giving back-to-back bursts with a 1-cycle gap.

## Test plan
- Masked write: write 0x11..11 to addr 5, then 0xFF..FF with wmask=9'h001 -> a burst of length 1 from base 5 returns 0x11..11FF.
- Streaming: preload addr i = i for 0..15; burst base 0, len 16, rready=1 -> 16 words 0..15 on consecutive cycles, rlast only on word 15, burst_busy drops at T+18.
- Backpressure: same burst with rready toggled pseudo-randomly -> all 16 words in order, rdata stable while stalled, never more than 2 words buffered.
- Wrap and bounds: burst base DEPTH-2, len 4 -> addresses 638, 639, 0, 1. A len-0 command and a len-641 command each leave burst_busy=0.
- Abort and collisions:
  - burst_abort after 3 words -> rvalid=0 the next cycle, then a new burst runs correctly.
  - burst_start while busy -> ignored.
  - A write to an address in the same cycle it is issued -> the old value is returned.
- Reset mid-burst: rst_n=0 at word 4 of 10 -> rvalid=0 and burst_busy=0 immediately, and stay 0 after release until a new burst_start.
